// File: rtl/fence_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fence_seq_pkg
//  Description : Shared types and helpers for the FENCE.I / WFI sequencer.
//                Holds the sequencer state enum and the two routing helpers
//                that pick the next step when a cache is configured out.
//  Revision    : 1.0 - initial release
// ============================================================================
package fence_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DRAIN     = 3'd1,
    DFLUSH    = 3'd2,
    IINV      = 3'd3,
    DONE      = 3'd4,
    WFI_SLEEP = 3'd5
  } fence_seq_state_t;

  // Step taken once the data-memory port has drained: flush the dcache if
  // present, otherwise invalidate the icache, otherwise retire immediately.
  function automatic fence_seq_state_t post_drain_state(input logic has_dcache,
                                                        input logic has_icache);
    fence_seq_state_t nxt;
    if (has_dcache)      nxt = DFLUSH;
    else if (has_icache) nxt = IINV;
    else                 nxt = DONE;
    return nxt;
  endfunction

  // Step taken once the dcache flush has completed.
  function automatic fence_seq_state_t post_dflush_state(input logic has_icache);
    fence_seq_state_t nxt;
    if (has_icache) nxt = IINV;
    else            nxt = DONE;
    return nxt;
  endfunction

endpackage : fence_seq_pkg
`default_nettype wire

// File: rtl/fence_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fence_sequencer
//  Description : Sequences a held FENCE.I (drain data memory, flush dcache,
//                invalidate icache, retire) and a held WFI (optional sleep
//                until an interrupt is pending, then retire). The pipeline is
//                stalled for the whole sequence and released in the retire
//                cycle, where seq_done pulses for one cycle.
//
//  Configuration macro:
//    WFI_SLEEP_EN - when defined, WFI sleeps in WFI_SLEEP until irq_pending;
//                   when undefined, WFI retires as a one-cycle NOP and
//                   irq_pending is unused.
//
//  Parameters:
//    DCACHE_PRESENT - 0 skips the DFLUSH step
//    ICACHE_PRESENT - 0 skips the IINV step
//
//  Ports:
//    CLK          in  clock, rising edge
//    nRST         in  asynchronous active-low reset
//    ifence       in  decoded FENCE.I held in execute
//    wfi          in  decoded WFI held in execute
//    dmem_busy    in  data-memory transaction outstanding
//    dflush_done  in  pulse: dcache writeback/flush complete
//    iclear_done  in  pulse: icache invalidate complete
//    irq_pending  in  any enabled interrupt pending
//    dflush_req   out dcache flush request (level)
//    iclear_req   out icache invalidate request (level)
//    stall        out freeze fetch and execute
//    seq_done     out one-cycle retire pulse for the held instruction
//
//  Revision    : 1.0 - initial release
// ============================================================================
module fence_sequencer
  import fence_seq_pkg::*;
#(
  parameter int unsigned DCACHE_PRESENT = 1,
  parameter int unsigned ICACHE_PRESENT = 1
) (
  input  logic CLK,
  input  logic nRST,
  input  logic ifence,
  input  logic wfi,
  input  logic dmem_busy,
  input  logic dflush_done,
  input  logic iclear_done,
  input  logic irq_pending,
  output logic dflush_req,
  output logic iclear_req,
  output logic stall,
  output logic seq_done
);

  localparam logic c_has_dcache = (DCACHE_PRESENT != 0);
  localparam logic c_has_icache = (ICACHE_PRESENT != 0);

  fence_seq_state_t r_state;
  fence_seq_state_t w_next_state;

  // Where an accepted WFI goes from IDLE, and whether a sleeping core wakes.
  fence_seq_state_t w_wfi_target;
  logic             w_wake;

`ifdef WFI_SLEEP_EN
  assign w_wfi_target = irq_pending ? DONE : WFI_SLEEP;
  assign w_wake       = irq_pending;
`else
  // WFI is a single-cycle NOP. WFI_SLEEP cannot be entered; should it ever
  // be reached it leaves on the next cycle rather than locking up.
  logic w_unused_irq;
  assign w_unused_irq = irq_pending;
  assign w_wfi_target = DONE;
  assign w_wake       = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Requests are only sampled in IDLE; done pulses are only
  // looked at in the state that issued the matching request, so strays and
  // pulses left over from before a reset fall on the floor.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (ifence) begin
          w_next_state = DRAIN;
        end else if (wfi) begin
          w_next_state = w_wfi_target;
        end
      end
      DRAIN: begin
        if (!dmem_busy) begin
          w_next_state = post_drain_state(c_has_dcache, c_has_icache);
        end
      end
      DFLUSH: begin
        if (dflush_done) begin
          w_next_state = post_dflush_state(c_has_icache);
        end
      end
      IINV: begin
        if (iclear_done) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      WFI_SLEEP: begin
        if (w_wake) begin
          w_next_state = DONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. Requests are decoded from a single state each, so they can
  // never overlap. In IDLE the stall is combinational from the held request
  // so the instruction is frozen in the very cycle it is decoded.
  // --------------------------------------------------------------------------
  always_comb begin
    dflush_req = 1'b0;
    iclear_req = 1'b0;
    stall      = 1'b0;
    seq_done   = 1'b0;
    case (r_state)
      IDLE: begin
        stall = ifence | wfi;
      end
      DRAIN: begin
        stall = 1'b1;
      end
      DFLUSH: begin
        stall      = 1'b1;
        dflush_req = 1'b1;
      end
      IINV: begin
        stall      = 1'b1;
        iclear_req = 1'b1;
      end
      DONE: begin
        seq_done = 1'b1;
      end
      WFI_SLEEP: begin
        stall = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule : fence_sequencer
`default_nettype wire

// File: tb/tb_fence_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fence_sequencer
//  Description : Directed, table-driven bench for fence_sequencer. One
//                instance uses the default cache configuration, a second has
//                both caches configured out. Expected values are written by
//                hand from the intended cycle-by-cycle behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fence_sequencer;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ifence = 1'b0;
  logic wfi = 1'b0;
  logic dmem_busy = 1'b0;
  logic dflush_done = 1'b0;
  logic iclear_done = 1'b0;
  logic irq_pending = 1'b0;

  logic dflush_req, iclear_req, stall, seq_done;
  logic nc_dflush_req, nc_iclear_req, nc_stall, nc_seq_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  fence_sequencer #(
    .DCACHE_PRESENT(1),
    .ICACHE_PRESENT(1)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .ifence     (ifence),
    .wfi        (wfi),
    .dmem_busy  (dmem_busy),
    .dflush_done(dflush_done),
    .iclear_done(iclear_done),
    .irq_pending(irq_pending),
    .dflush_req (dflush_req),
    .iclear_req (iclear_req),
    .stall      (stall),
    .seq_done   (seq_done)
  );

  fence_sequencer #(
    .DCACHE_PRESENT(0),
    .ICACHE_PRESENT(0)
  ) dut_nc (
    .CLK        (CLK),
    .nRST       (nRST),
    .ifence     (ifence),
    .wfi        (wfi),
    .dmem_busy  (dmem_busy),
    .dflush_done(dflush_done),
    .iclear_done(iclear_done),
    .irq_pending(irq_pending),
    .dflush_req (nc_dflush_req),
    .iclear_req (nc_iclear_req),
    .stall      (nc_stall),
    .seq_done   (nc_seq_done)
  );

  typedef struct {
    logic ifence, wfi, busy, dfd, icd;
    logic e_stall, e_dreq, e_ireq, e_done;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_main(input string tag, input logic e_stall, input logic e_dreq,
                          input logic e_ireq, input logic e_done);
    chk({tag, ".stall"},    stall,      e_stall);
    chk({tag, ".dflush"},   dflush_req, e_dreq);
    chk({tag, ".iclear"},   iclear_req, e_ireq);
    chk({tag, ".seq_done"}, seq_done,   e_done);
  endtask

  task automatic chk_nc(input string tag, input logic e_stall, input logic e_done);
    chk({tag, ".stall"},    nc_stall,      e_stall);
    chk({tag, ".dflush"},   nc_dflush_req, 1'b0);
    chk({tag, ".iclear"},   nc_iclear_req, 1'b0);
    chk({tag, ".seq_done"}, nc_seq_done,   e_done);
  endtask

  initial begin
    //            ifn wfi bsy dfd icd | stl drq irq dne
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // idle
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0}; // IDLE, comb stall
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0}; // DRAIN
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0}; // DFLUSH, stray icd
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0}; // DFLUSH, done
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0}; // IINV
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0}; // IINV, done
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1}; // DONE, ifence held
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // IDLE
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0}; // IDLE -> min latency
    vecs[10] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0}; // DRAIN, stray dfd
    vecs[11] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0}; // DFLUSH same-cycle done
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0}; // IINV same-cycle done
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1}; // DONE
    vecs[14] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0}; // IDLE, strays
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // IDLE
    vecs[16] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0}; // IDLE, busy
    vecs[17] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0}; // DRAIN 1
    vecs[18] = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0}; // DRAIN 2
    vecs[19] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0}; // DRAIN 3
    vecs[20] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0}; // DFLUSH
    vecs[21] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0}; // IINV
    vecs[22] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1}; // DONE
    vecs[23] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // IDLE
    vecs[24] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0}; // ifence+wfi
    vecs[25] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0}; // DRAIN (fence won)
    vecs[26] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0}; // DFLUSH
    vecs[27] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0}; // IINV
    vecs[28] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1}; // DONE
    vecs[29] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0}; // IDLE

    // ---------------- reset state ----------------
    #2;
    ifence = 1'b1;
    #1 chk_main("rst_ifence", 1'b1, 1'b0, 1'b0, 1'b0);
    ifence = 1'b0;
    dflush_done = 1'b1;
    iclear_done = 1'b1;
    #1 chk_main("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    dflush_done = 1'b0;
    iclear_done = 1'b0;
    nRST = 1'b1;

    // ---------------- vector table ----------------
    for (int i = 0; i < NVEC; i++) begin
      @(negedge CLK);
      ifence      = vecs[i].ifence;
      wfi         = vecs[i].wfi;
      dmem_busy   = vecs[i].busy;
      dflush_done = vecs[i].dfd;
      iclear_done = vecs[i].icd;
      #2;
      chk_main($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_dreq,
               vecs[i].e_ireq, vecs[i].e_done);
      chk($sformatf("vec%0d.excl", i), dflush_req & iclear_req, 1'b0);
    end

    // ---------------- WFI with irq already pending ----------------
    @(negedge CLK);
    wfi = 1'b1; irq_pending = 1'b1;
    #2 chk_main("wfi_irq.c0", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    wfi = 1'b0; irq_pending = 1'b0;
    #2 chk_main("wfi_irq.c1", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    #2 chk_main("wfi_irq.c2", 1'b0, 1'b0, 1'b0, 1'b0);

    // ---------------- WFI, irq raised late ----------------
    for (int c = 0; c <= 11; c++) begin
      logic e_stall, e_done;
      @(negedge CLK);
`ifdef WFI_SLEEP_EN
      wfi         = (c < 10);
      irq_pending = (c >= 9);
      e_stall     = (c <= 9);
      e_done      = (c == 10);
`else
      wfi         = (c == 0);
      irq_pending = (c >= 9);
      e_stall     = (c == 0);
      e_done      = (c == 1);
`endif
      #2 chk_main($sformatf("wfi_sleep.c%0d", c), e_stall, 1'b0, 1'b0, e_done);
    end
    @(negedge CLK);
    irq_pending = 1'b0;

    // ---------------- reset in the middle of a flush ----------------
    @(negedge CLK);
    ifence = 1'b1;
    #2 chk_main("rstmid.idle", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    #2 chk_main("rstmid.drain", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    #2 chk_main("rstmid.dflush", 1'b1, 1'b1, 1'b0, 1'b0);
    #1 nRST = 1'b0;
    #1 chk_main("rstmid.inrst", 1'b1, 1'b0, 1'b0, 1'b0);
    ifence = 1'b0;
    #1 chk_main("rstmid.inrst_noreq", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    dflush_done = 1'b1;
    #2 chk_main("rstmid.stray", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    dflush_done = 1'b0;
    #2 chk_main("rstmid.after", 1'b0, 1'b0, 1'b0, 1'b0);

    // ---------------- no caches: DRAIN then DONE ----------------
    @(negedge CLK);
    ifence = 1'b1;
    #2 chk_nc("nc.c0", 1'b1, 1'b0);
    @(negedge CLK);
    #2 chk_nc("nc.c1", 1'b1, 1'b0);
    @(negedge CLK);
    ifence = 1'b0;
    #2 chk_nc("nc.c2", 1'b0, 1'b1);
    @(negedge CLK);
    #2 chk_nc("nc.c3", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fence_sequencer
`default_nettype wire

// File: doc/fence_sequencer.md
FENCE_SEQUENCER -- requirements
Module: fence_sequencer

Interface
REQ-001 SHALL have parameter DCACHE_PRESENT, default 1, meaning: when 0, the DFLUSH state is skipped.
REQ-002 SHALL have parameter ICACHE_PRESENT, default 1, meaning: when 0, the IINV state is skipped.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; one clock, rising edge.
REQ-004 SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port ifence, input, 1: decoded FENCE.I held in execute.
REQ-006 SHALL have port wfi, input, 1: decoded WFI held in execute.
REQ-007 SHALL have port dmem_busy, input, 1: data-memory transaction outstanding.
REQ-008 SHALL have port dflush_done, input, 1: one-cycle pulse, dcache writeback and flush complete.
REQ-009 SHALL have port iclear_done, input, 1: one-cycle pulse, icache invalidate complete.
REQ-010 SHALL have port irq_pending, input, 1: any enabled interrupt pending.
REQ-011 SHALL have port dflush_req, output, 1: dcache flush request, level.
REQ-012 SHALL have port iclear_req, output, 1: icache invalidate request, level.
REQ-013 SHALL have port stall, output, 1: freeze fetch and execute.
REQ-014 SHALL have port seq_done, output, 1: one-cycle retire pulse for the held instruction.

Function
REQ-015 SHALL implement the states IDLE, DRAIN, DFLUSH, IINV, DONE and WFI_SLEEP.
REQ-016 In IDLE with ifence=1, SHALL go to DRAIN; ifence has priority over wfi if both are asserted.
REQ-017 DRAIN: SHALL stay while dmem_busy=1; when dmem_busy=0, SHALL go to DFLUSH, or to IINV if DCACHE_PRESENT=0, or to DONE if both caches are absent.
REQ-018 DFLUSH: SHALL hold dflush_req=1; on dflush_done, SHALL go to IINV, or to DONE if ICACHE_PRESENT=0.
REQ-019 IINV: SHALL hold iclear_req=1; on iclear_done, SHALL go to DONE.
REQ-020 DONE: SHALL drive seq_done=1 and stall=0 for exactly one cycle, then go to IDLE unconditionally.
REQ-021 stall SHALL be 1 in DRAIN, DFLUSH, IINV and WFI_SLEEP, and combinationally 1 in IDLE when ifence or wfi is asserted; it SHALL be 0 otherwise.
REQ-022 ifence/wfi SHALL be sampled only in IDLE; the still-held request is ignored during DONE (no re-trigger).
REQ-023 Done pulses (dflush_done, iclear_done) arriving in a state that does not expect them SHALL be ignored.
REQ-024 A done pulse arriving in the same cycle its request first rises SHALL be accepted.
REQ-025 Minimum FENCE.I latency with both caches present, dmem idle and same-cycle done pulses SHALL be 4 cycles (DRAIN, DFLUSH, IINV, DONE).
REQ-026 dflush_req and iclear_req SHALL never be asserted simultaneously.

Reset
REQ-027 nRST low SHALL force IDLE immediately, including mid-flush.
REQ-028 While reset is asserted, dflush_req, iclear_req and seq_done SHALL be 0, and stall SHALL follow REQ-021 for IDLE.
REQ-029 After reset, a pending done pulse SHALL be ignored.

Configuration
REQ-030 Macro WFI_SLEEP_EN SHALL control WFI sleep support.
REQ-031 With WFI_SLEEP_EN defined: IDLE with wfi=1 and irq_pending=0 SHALL go to WFI_SLEEP; it SHALL stay while irq_pending=0, then go to DONE. IDLE with wfi=1 and irq_pending=1 SHALL go directly to DONE.
REQ-032 Without WFI_SLEEP_EN: wfi SHALL go IDLE to DONE, giving a 1-cycle NOP. WFI_SLEEP SHALL be unreachable, and irq_pending SHALL be unused.

Structure
REQ-033 The fence_seq_state_t enum (IDLE, DRAIN, DFLUSH, IINV, DONE, WFI_SLEEP) SHALL be defined in a shared package, fence_seq_pkg.
REQ-034 The block SHALL be a single flat FSM (state register plus next-state/output logic); no sub-module.
REQ-035 The control-unit ifence and wfi fields SHALL connect directly to this block.

Verification
REQ-036 Scenario: ifence=1, dmem_busy=0, dflush_done and iclear_done each returned 2 cycles after their request -> states DRAIN(1), DFLUSH(2), IINV(2), DONE(1); seq_done high once, at cycle 6.
REQ-037 Scenario: ifence=1 with dmem_busy=1 for 3 cycles -> 3 DRAIN cycles with dflush_req=0, then dflush_req rises.
REQ-038 Scenario: DCACHE_PRESENT=0, ICACHE_PRESENT=0, ifence=1 -> DRAIN then DONE; seq_done at cycle 2; neither request is ever asserted.
REQ-039 Scenario: nRST pulsed low during DFLUSH, with dflush_done arriving 1 cycle after release -> IDLE, dflush_req=0, the pulse is ignored, no seq_done.
REQ-040 Scenario: WFI_SLEEP_EN defined, wfi=1, irq_pending raised after 10 cycles -> stall high for 10 cycles, then seq_done once. Without the macro -> seq_done on cycle 1.
REQ-041 Scenario: ifence=1 and wfi=1 together -> fence sequence taken; wfi behaviour not started.
